axi_vector_modulator_regmap: RTL and testbench
==============================================

# axi_vector_modulator_regmap

AXI4-Lite responder that implements the vector-modulator control/status register file driven by the simulation bench and the PS software. It decodes word-indexed register accesses, holds the control registers that configure the vector-modulator datapath, and exposes live status and saturating buffer-error counters. It sits between the PS AXI interconnect and the vector-modulator core, in the same clock domain as the bus.

## Interface
Parameters:
- ADDR_WIDTH, 7, byte-address width. Register index = s_axi_awaddr/araddr[6:2].
- FAST_DIV_RST, 32'd1, reset value of the fast_clk_div register.
- SLOW_DIV_RST, 32'd1, reset value of the slow_clk_div register.

Ports:
- s_axi_aclk  in  1  sole clock.
- s_axi_areset  in  1  synchronous, active-high reset.
- s_axi_awvalid/awready  in/out  1  write-address handshake; s_axi_awaddr  in  ADDR_WIDTH.
- s_axi_wvalid/wready  in/out  1  write-data handshake; s_axi_wdata  in  32; s_axi_wstrb  in  4.
- s_axi_bvalid/bready  out/in  1  write response; s_axi_bresp  out  2.
- s_axi_arvalid/arready  in/out  1  read-address handshake; s_axi_araddr  in  ADDR_WIDTH.
- s_axi_rvalid/rready  out/in  1  read response; s_axi_rdata  out  32; s_axi_rresp  out  2.
- Control outputs, each out 32: vm_ctrls, fast_clk_div, slow_clk_div, pulse_cnt, mask_base_addr, mask_row_len, mask_row_valid_len, mask_len, column_len, vm_active_modes, phase_idle_modes, atten_idle_modes.
- ctrl_rst  out  1  one-cycle pulse.
- vm_status  in  32; vat_val  in  6; ps_val  in  6 (zero-extended on read).
- buf_overflow_pulse, buf_underflow_pulse  in  1  one-cycle error events.

## Operation
- Register indices: 0 vm_ctrls, 1 fast_clk_div, 2 slow_clk_div, 3 pulse_cnt, 4 mask_base_addr, 5 mask_row_len, 6 mask_row_valid_len, 7 mask_len, 8 column_len, 9 vm_active_modes, 10 phase_idle_modes, 11 atten_idle_modes, 12 ctrl_rst, 13 vm_status, 14 vat_val, 15 ps_val, 16 overflow count, 17 underflow count. Indices 18–31 are unmapped.
- Indices 0–11 are R/W. Writes honour wstrb per byte. Reads return the stored value.
- Index 12: a write with wdata[0]=1 and wstrb[0]=1 pulses ctrl_rst for exactly one cycle. It reads as 0.
- Indices 13–15 are read-only. A write returns SLVERR and has no effect.
- Indices 16–17 are 32-bit counters. Each increments on its pulse input and saturates at 0xFFFFFFFF. Any write clears the counter and returns OKAY. If a clear and a pulse land in the same cycle, the result is 1.
- Unmapped index: writes return SLVERR with no effect; reads return SLVERR with rdata 0.
- Write FSM states:
  - W_IDLE: AW and W are accepted independently and each is latched.
  - W_RESP: entered once both are latched; the register is written on entry; bvalid is held until bready.
  - Return to W_IDLE after the B handshake.
  - awready is low while an address is latched or the FSM is in W_RESP; wready follows the same rule for data.
- Read FSM states:
  - R_IDLE: arready=1.
  - R_DATA: entered on the AR handshake; rdata and rresp are registered; rvalid is held until rready.
  - Return to R_IDLE after the R handshake.
- Read and write paths are independent. A read of the same register in the cycle it is written returns the old value.
- bresp and rresp encodings: OKAY=2'b00, SLVERR=2'b10.

## Timing
- Reset values: all ready/valid outputs 0; bresp and rresp 0; rdata 0; ctrl_rst 0; counters 0; control registers 0, except fast_clk_div=FAST_DIV_RST and slow_clk_div=SLOW_DIV_RST.
- awready, wready and arready rise in the first cycle after reset deasserts.
- Write latency:
  - AW and W in the same cycle: bvalid asserts the next cycle.
  - Control output updates in the same cycle bvalid asserts.
  - ctrl_rst pulses in the same cycle bvalid asserts.
- Read latency: rvalid asserts the cycle after the AR handshake. rdata is stable while rvalid=1 and rready=0.
- Back-to-back throughput (bready/rready held high): one write every 2 cycles and one read every 2 cycles.
- Status inputs are sampled at the AR handshake cycle.
- Reset asserted mid-transaction: both FSMs return to idle and pending responses are dropped. No ctrl_rst pulse is generated.

## Test plan
- Reset -> read idx 1 returns 0x00000001 with OKAY; read idx 0 returns 0x00000000.
- Write idx 3 = 0xA5A5A5A5 with wstrb=4'b0011 -> pulse_cnt = 0x0000A5A5; bresp=OKAY; readback matches.
- AW presented 3 cycles before W (idx 12, data 1) -> exactly one ctrl_rst pulse, coincident with bvalid; idx 12 then reads 0.
- 5 overflow pulses, then read idx 16 -> 5. Write idx 16 in the same cycle as a pulse -> readback 1.
- Write idx 13 -> SLVERR with vm_status unaffected. Read idx 20 -> SLVERR, rdata 0.
- rready held low for 4 cycles with vat_val=6'h2A -> rvalid stays high and rdata stays 0x0000002A. Reset asserted while bvalid is high -> bvalid is 0 on the next cycle.

Source files
------------

// File: rtl/axi_vector_modulator_regmap.sv
// AXI4-Lite register file for the vector-modulator: control registers,
// a ctrl_rst strobe, live status readback and saturating buffer-error counters.
//
// Write FSM
//   state  | meaning
//   W_IDLE | accepting AW and W independently, each latched until its partner arrives
//   W_RESP | register written on entry, bvalid held until bready
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for an address
//   R_DATA | rdata/rresp registered at the AR handshake, rvalid held until rready
module axi_vector_modulator_regmap #(
  parameter int          ADDR_WIDTH   = 7,
  parameter logic [31:0] FAST_DIV_RST = 32'd1,
  parameter logic [31:0] SLOW_DIV_RST = 32'd1
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [1:0]            s_axi_bresp,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic [31:0]           vm_ctrls,
  output logic [31:0]           fast_clk_div,
  output logic [31:0]           slow_clk_div,
  output logic [31:0]           pulse_cnt,
  output logic [31:0]           mask_base_addr,
  output logic [31:0]           mask_row_len,
  output logic [31:0]           mask_row_valid_len,
  output logic [31:0]           mask_len,
  output logic [31:0]           column_len,
  output logic [31:0]           vm_active_modes,
  output logic [31:0]           phase_idle_modes,
  output logic [31:0]           atten_idle_modes,
  output logic                  ctrl_rst,
  input  logic [31:0]           vm_status,
  input  logic [5:0]            vat_val,
  input  logic [5:0]            ps_val,
  input  logic                  buf_overflow_pulse,
  input  logic                  buf_underflow_pulse
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t    w_state, w_next;
  r_state_t    r_state, r_next;
  logic        ready_en;
  logic        aw_held, w_held;
  logic [4:0]  aw_idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_fire, w_fire, ar_fire, do_write;
  logic [4:0]  wr_idx, rd_idx;
  logic [31:0] wr_data, rd_val;
  logic [3:0]  wr_strb;
  logic [1:0]  wr_resp, rd_resp;
  logic [31:0] ctrl_q [12];
  logic [31:0] ovf_cnt, unf_cnt;

  assign aw_fire  = s_axi_awvalid && s_axi_awready;
  assign w_fire   = s_axi_wvalid && s_axi_wready;
  assign ar_fire  = s_axi_arvalid && s_axi_arready;
  assign wr_idx   = aw_held ? aw_idx_q : s_axi_awaddr[6:2];
  assign wr_data  = w_held ? wdata_q : s_axi_wdata;
  assign wr_strb  = w_held ? wstrb_q : s_axi_wstrb;
  assign do_write = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
  assign rd_idx   = s_axi_araddr[6:2];

  // Holds the ready outputs low until the first cycle after reset releases
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) ready_en <= 1'b0;
    else              ready_en <= 1'b1;
  end

  // Write FSM state register
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) w_state <= W_IDLE;
    else              w_state <= w_next;
  end

  // Write FSM next state
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (do_write) w_next = W_RESP;
      W_RESP:  if (s_axi_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write FSM outputs
  always_comb begin
    s_axi_awready = ready_en && (w_state == W_IDLE) && !aw_held;
    s_axi_wready  = ready_en && (w_state == W_IDLE) && !w_held;
    s_axi_bvalid  = (w_state == W_RESP);
  end

  // Latches AW and W that arrive ahead of their partner
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (do_write) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_fire) begin
        aw_held  <= 1'b1;
        aw_idx_q <= s_axi_awaddr[6:2];
      end
      if (w_fire) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
    end
  end

  // Write response decode: status registers and the unmapped range are rejected
  always_comb begin
    wr_resp = RESP_OKAY;
    if ((wr_idx >= 5'd13 && wr_idx <= 5'd15) || wr_idx >= 5'd18) wr_resp = RESP_SLVERR;
  end

  // Registers bresp and the ctrl_rst strobe on the write that enters W_RESP
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      s_axi_bresp <= RESP_OKAY;
      ctrl_rst    <= 1'b0;
    end else begin
      if (do_write) s_axi_bresp <= wr_resp;
      ctrl_rst <= do_write && (wr_idx == 5'd12) && wr_data[0] && wr_strb[0];
    end
  end

  // Control register file with byte-lane strobes
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      for (int i = 0; i < 12; i++) ctrl_q[i] <= '0;
      ctrl_q[1] <= FAST_DIV_RST;
      ctrl_q[2] <= SLOW_DIV_RST;
    end else if (do_write && wr_idx < 5'd12) begin
      for (int b = 0; b < 4; b++)
        if (wr_strb[b]) ctrl_q[wr_idx[3:0]][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  // Saturating error counters; a clear coinciding with a pulse leaves a count of one
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else begin
      if (do_write && wr_idx == 5'd16)         ovf_cnt <= buf_overflow_pulse ? 32'd1 : 32'd0;
      else if (buf_overflow_pulse && ~&ovf_cnt) ovf_cnt <= ovf_cnt + 32'd1;
      if (do_write && wr_idx == 5'd17)          unf_cnt <= buf_underflow_pulse ? 32'd1 : 32'd0;
      else if (buf_underflow_pulse && ~&unf_cnt) unf_cnt <= unf_cnt + 32'd1;
    end
  end

  // Read FSM state register
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) r_state <= R_IDLE;
    else              r_state <= r_next;
  end

  // Read FSM next state
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_next = R_DATA;
      R_DATA:  if (s_axi_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read FSM outputs
  always_comb begin
    s_axi_arready = ready_en && (r_state == R_IDLE);
    s_axi_rvalid  = (r_state == R_DATA);
  end

  // Read mux; status inputs are captured only at the AR handshake
  always_comb begin
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    if (rd_idx < 5'd12) rd_val = ctrl_q[rd_idx[3:0]];
    else begin
      case (rd_idx)
        5'd12:   rd_val = '0;
        5'd13:   rd_val = vm_status;
        5'd14:   rd_val = {26'd0, vat_val};
        5'd15:   rd_val = {26'd0, ps_val};
        5'd16:   rd_val = ovf_cnt;
        5'd17:   rd_val = unf_cnt;
        default: rd_resp = RESP_SLVERR;
      endcase
    end
  end

  // Read data register, held stable while the response is stalled
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else if (ar_fire) begin
      s_axi_rdata <= rd_val;
      s_axi_rresp <= rd_resp;
    end
  end

  assign vm_ctrls           = ctrl_q[0];
  assign fast_clk_div       = ctrl_q[1];
  assign slow_clk_div       = ctrl_q[2];
  assign pulse_cnt          = ctrl_q[3];
  assign mask_base_addr     = ctrl_q[4];
  assign mask_row_len       = ctrl_q[5];
  assign mask_row_valid_len = ctrl_q[6];
  assign mask_len           = ctrl_q[7];
  assign column_len         = ctrl_q[8];
  assign vm_active_modes    = ctrl_q[9];
  assign phase_idle_modes   = ctrl_q[10];
  assign atten_idle_modes   = ctrl_q[11];

endmodule

// File: tb/tb_axi_vector_modulator_regmap.sv
// Bench for axi_vector_modulator_regmap: directed AXI-Lite traffic with
// expected responses queued by the drivers and checked by a monitor.
module tb_axi_vector_modulator_regmap;

  logic        clk = 1'b0;
  logic        areset;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [6:0]  awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [31:0] vm_ctrls, fast_clk_div, slow_clk_div, pulse_cnt, mask_base_addr;
  logic [31:0] mask_row_len, mask_row_valid_len, mask_len, column_len;
  logic [31:0] vm_active_modes, phase_idle_modes, atten_idle_modes;
  logic        ctrl_rst;
  logic [31:0] vm_status;
  logic [5:0]  vat_val, ps_val;
  logic        buf_overflow_pulse, buf_underflow_pulse;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  int total = 0;
  int bad   = 0;
  int rst_pulses = 0;
  int rst_misaligned = 0;
  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  always #5 clk = ~clk;

  axi_vector_modulator_regmap dut (
    .s_axi_aclk(clk), .s_axi_areset(areset),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .vm_ctrls(vm_ctrls), .fast_clk_div(fast_clk_div), .slow_clk_div(slow_clk_div),
    .pulse_cnt(pulse_cnt), .mask_base_addr(mask_base_addr), .mask_row_len(mask_row_len),
    .mask_row_valid_len(mask_row_valid_len), .mask_len(mask_len), .column_len(column_len),
    .vm_active_modes(vm_active_modes), .phase_idle_modes(phase_idle_modes),
    .atten_idle_modes(atten_idle_modes), .ctrl_rst(ctrl_rst),
    .vm_status(vm_status), .vat_val(vat_val), .ps_val(ps_val),
    .buf_overflow_pulse(buf_overflow_pulse), .buf_underflow_pulse(buf_underflow_pulse)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  // Response monitor: pops the queued expectation on every completed B or R handshake
  initial begin : monitor
    logic [1:0]  eb;
    logic [33:0] er;
    forever begin
      @(negedge clk);
      if (ctrl_rst) begin
        rst_pulses++;
        if (!bvalid) rst_misaligned++;
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) timeout("b_unexpected");
        else begin
          eb = bq.pop_front();
          chk("bresp", {30'd0, bresp}, {30'd0, eb});
        end
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) timeout("r_unexpected");
        else begin
          er = rq.pop_front();
          chk("rdata", rdata, er[31:0]);
          chk("rresp", {30'd0, rresp}, {30'd0, er[33:32]});
        end
      end
    end
  end

  task automatic axi_write(input logic [4:0] idx, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp_resp, input int aw_lead, input bit ovf_with,
                           input bit wait_b);
    int cyc;
    bit aw_done, w_done, aw_hs, w_hs, b_hs;
    if (wait_b) bq.push_back(exp_resp);
    awaddr  = {idx, 2'b00};
    awvalid = 1'b1;
    wdata   = data;
    wstrb   = strb;
    wvalid  = (aw_lead == 0);
    buf_overflow_pulse = ovf_with;
    cyc = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      buf_overflow_pulse = 1'b0;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
      cyc++;
      if (aw_lead > 0 && cyc == aw_lead) wvalid = 1'b1;
    end
    if (!(aw_done && w_done)) begin
      timeout("aw_w_handshake");
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end
    if (wait_b) begin
      b_hs = 0; cyc = 0;
      while (!b_hs && cyc < 20) begin
        @(negedge clk);
        b_hs = bvalid && bready;
        @(posedge clk); #1;
        cyc++;
      end
      if (!b_hs) timeout("b_handshake");
    end
  endtask

  task automatic axi_read(input logic [4:0] idx, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int hold);
    int cyc;
    bit hs;
    rq.push_back({exp_resp, exp_data});
    if (hold > 0) rready = 1'b0;
    araddr  = {idx, 2'b00};
    arvalid = 1'b1;
    hs = 0; cyc = 0;
    while (!hs && cyc < 50) begin
      @(negedge clk);
      hs = arvalid && arready;
      @(posedge clk); #1;
      cyc++;
    end
    arvalid = 1'b0;
    if (!hs) timeout("ar_handshake");
    if (hold > 0) vat_val = vat_val ^ 6'h3F;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_rvalid", {31'd0, rvalid}, 32'd1);
      chk("hold_rdata", rdata, exp_data);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    hs = 0; cyc = 0;
    while (!hs && cyc < 20) begin
      @(negedge clk);
      hs = rvalid && rready;
      @(posedge clk); #1;
      cyc++;
    end
    if (!hs) timeout("r_handshake");
  endtask

  task automatic pulse_err(input bit ovf, input int n);
    for (int i = 0; i < n; i++) begin
      if (ovf) buf_overflow_pulse = 1'b1; else buf_underflow_pulse = 1'b1;
      @(posedge clk); #1;
      buf_overflow_pulse  = 1'b0;
      buf_underflow_pulse = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin : stim
    int p0;
    int cyc;
    areset = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    vm_status = '0; vat_val = '0; ps_val = '0;
    buf_overflow_pulse = 0; buf_underflow_pulse = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_ctrl_rst", {31'd0, ctrl_rst}, 32'd0);
    chk("rst_fast_div", fast_clk_div, 32'd1);
    chk("rst_slow_div", slow_clk_div, 32'd1);
    chk("rst_vm_ctrls", vm_ctrls, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    areset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after_rst", {29'd0, awready, wready, arready}, 32'd7);
    @(posedge clk); #1;

    axi_read(5'd1, 32'h0000_0001, OKAY, 0);
    axi_read(5'd0, 32'h0000_0000, OKAY, 0);
    axi_read(5'd2, 32'h0000_0001, OKAY, 0);

    axi_write(5'd3, 32'hA5A5_A5A5, 4'b0011, OKAY, 0, 0, 1);
    chk("pulse_cnt_lo", pulse_cnt, 32'h0000_A5A5);
    axi_read(5'd3, 32'h0000_A5A5, OKAY, 0);
    axi_write(5'd3, 32'h1234_5678, 4'b1100, OKAY, 0, 0, 1);
    chk("pulse_cnt_hi", pulse_cnt, 32'h1234_A5A5);
    axi_write(5'd9, 32'hCAFE_F00D, 4'b1111, OKAY, 0, 0, 1);
    chk("vm_active_modes", vm_active_modes, 32'hCAFE_F00D);
    axi_read(5'd11, 32'h0000_0000, OKAY, 0);

    p0 = rst_pulses;
    axi_write(5'd12, 32'h0000_0001, 4'b0001, OKAY, 3, 0, 1);
    chk("ctrl_rst_count", rst_pulses - p0, 32'd1);
    chk("ctrl_rst_align", rst_misaligned, 32'd0);
    axi_read(5'd12, 32'h0000_0000, OKAY, 0);
    p0 = rst_pulses;
    axi_write(5'd12, 32'h0000_0001, 4'b1110, OKAY, 0, 0, 1);
    chk("ctrl_rst_nostrb", rst_pulses - p0, 32'd0);

    pulse_err(1, 5);
    axi_read(5'd16, 32'd5, OKAY, 0);
    axi_write(5'd16, 32'h0, 4'b1111, OKAY, 0, 1, 1);
    axi_read(5'd16, 32'd1, OKAY, 0);
    pulse_err(0, 2);
    axi_read(5'd17, 32'd2, OKAY, 0);
    axi_write(5'd17, 32'h0, 4'b0000, OKAY, 0, 0, 1);
    axi_read(5'd17, 32'd0, OKAY, 0);

    vm_status = 32'hDEAD_BEEF;
    ps_val = 6'h3F;
    axi_write(5'd13, 32'h1111_1111, 4'b1111, SLVERR, 0, 0, 1);
    axi_read(5'd13, 32'hDEAD_BEEF, OKAY, 0);
    axi_read(5'd15, 32'h0000_003F, OKAY, 0);
    axi_write(5'd20, 32'h2222_2222, 4'b1111, SLVERR, 0, 0, 1);
    axi_read(5'd20, 32'h0000_0000, SLVERR, 0);

    vat_val = 6'h2A;
    axi_read(5'd14, 32'h0000_002A, OKAY, 4);

    bready = 1'b0;
    axi_write(5'd5, 32'h0000_0055, 4'b1111, OKAY, 0, 0, 0);
    @(negedge clk);
    chk("bvalid_before_rst", {31'd0, bvalid}, 32'd1);
    @(posedge clk); #1;
    areset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bvalid_after_rst", {31'd0, bvalid}, 32'd0);
    chk("awready_in_rst", {31'd0, awready}, 32'd0);
    chk("row_len_after_rst", mask_row_len, 32'd0);
    @(posedge clk); #1;
    areset = 1'b0;
    bready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("awready_after_rst2", {31'd0, awready}, 32'd1);
    @(posedge clk); #1;
    axi_read(5'd3, 32'h0000_0000, OKAY, 0);
    axi_read(5'd1, 32'h0000_0001, OKAY, 0);

    cyc = 0;
    while ((bq.size() != 0 || rq.size() != 0) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bq_drained", bq.size(), 32'd0);
    chk("rq_drained", rq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
